// File: rtl/ct_ciu_l2c_resp_buf_if.sv
// L2C completion capture / CIU response channel bundle for one L2C bank.
interface ct_ciu_l2c_resp_buf_if;
    logic         l2c_ciu_cmplt;
    logic [4:0]   l2c_ciu_resp;
    logic [3:0]   l2c_ciu_cp;
    logic [4:0]   l2c_ciu_sid;
    logic [511:0] l2c_ciu_data;
    logic         ciu_resp_rdy;
    logic         ciu_resp_vld;
    logic [4:0]   ciu_resp_sid;
    logic [3:0]   ciu_resp_cp;
    logic [4:0]   ciu_resp_resp;
    logic [255:0] ciu_resp_data;
    logic         ciu_resp_last;
    logic         l2c_issue_stall;
    logic         resp_buf_empty;
    logic         resp_buf_ovf_err;

    modport slave (
        input  l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid,
        input  l2c_ciu_data, ciu_resp_rdy,
        output ciu_resp_vld, ciu_resp_sid, ciu_resp_cp, ciu_resp_resp,
        output ciu_resp_data, ciu_resp_last,
        output l2c_issue_stall, resp_buf_empty, resp_buf_ovf_err
    );

    modport master (
        output l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid,
        output l2c_ciu_data, ciu_resp_rdy,
        input  ciu_resp_vld, ciu_resp_sid, ciu_resp_cp, ciu_resp_resp,
        input  ciu_resp_data, ciu_resp_last,
        input  l2c_issue_stall, resp_buf_empty, resp_buf_ovf_err
    );
endinterface

// File: rtl/ct_ciu_l2c_resp_buf.sv
// Captures L2C WB completions into a FIFO and drains them to the CIU
// response network as one or two 256-bit beats per entry.
module ct_ciu_l2c_resp_buf #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int STALL_TH = 2
) (
    input logic                   forever_cpuclk,
    input logic                   cpurst,
    ct_ciu_l2c_resp_buf_if.slave  bus
);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, ovf_q;
    logic             full, push, pop, head_cp0;

    logic [4:0]   sid_mem  [DEPTH];
    logic [4:0]   resp_mem [DEPTH];
    logic [3:0]   cp_mem   [DEPTH];
    logic [511:0] data_mem [DEPTH];

    assign full     = (count_q == CNT_W'(DEPTH));
    assign head_cp0 = cp_mem[rd_ptr_q][0];
    assign pop      = bus.ciu_resp_rdy &&
                      ((state_q == BEAT0 && !head_cp0) || state_q == BEAT1);
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push     = bus.l2c_ciu_cmplt && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (count_d != '0)
                    state_d = BEAT0;
            end
            BEAT0: begin
                if (bus.ciu_resp_rdy) begin
                    if (head_cp0)
                        state_d = BEAT1;
                    else
                        state_d = (count_d != '0) ? BEAT0 : IDLE;
                end
            end
            BEAT1: begin
                if (bus.ciu_resp_rdy)
                    state_d = (count_d != '0) ? BEAT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stall_q <= (DEPTH - int'(count_d)) <= STALL_TH;
            if (bus.l2c_ciu_cmplt && full && !pop)
                ovf_q <= 1'b1;
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ?
                            '0 : wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ?
                            '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Line data only loads for data-carrying completions
    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            sid_mem[wr_ptr_q]  <= bus.l2c_ciu_sid;
            resp_mem[wr_ptr_q] <= bus.l2c_ciu_resp;
            cp_mem[wr_ptr_q]   <= bus.l2c_ciu_cp;
            if (bus.l2c_ciu_cp[0])
                data_mem[wr_ptr_q] <= bus.l2c_ciu_data;
        end
    end

    always_comb begin
        bus.ciu_resp_vld  = (state_q != IDLE);
        bus.ciu_resp_sid  = '0;
        bus.ciu_resp_cp   = '0;
        bus.ciu_resp_resp = '0;
        bus.ciu_resp_data = '0;
        bus.ciu_resp_last = 1'b0;
        unique case (state_q)
            BEAT0: begin
                bus.ciu_resp_sid  = sid_mem[rd_ptr_q];
                bus.ciu_resp_cp   = cp_mem[rd_ptr_q];
                bus.ciu_resp_resp = resp_mem[rd_ptr_q];
                bus.ciu_resp_last = !head_cp0;
                if (head_cp0)
                    bus.ciu_resp_data = data_mem[rd_ptr_q][255:0];
            end
            BEAT1: begin
                bus.ciu_resp_sid  = sid_mem[rd_ptr_q];
                bus.ciu_resp_cp   = cp_mem[rd_ptr_q];
                bus.ciu_resp_resp = resp_mem[rd_ptr_q];
                bus.ciu_resp_last = 1'b1;
                bus.ciu_resp_data = data_mem[rd_ptr_q][511:256];
            end
            default: ;
        endcase
    end

    assign bus.l2c_issue_stall  = stall_q;
    assign bus.resp_buf_empty   = (count_q == '0) && (state_q == IDLE);
    assign bus.resp_buf_ovf_err = ovf_q;
endmodule
